cpu_out_display: RTL and testbench

- Far end of the CPU output bus: consumes the 4-bit `cpuOut` nibble driven by the CPU top.
- Keeps a 4-deep history of distinct output values.
- Drives a multiplexed 4-digit seven-segment display on the board.
- Sits beside the CPU top at board level, clocked from the same board clock.

---
 rtl/cpu_out_display_if.sv | 20 ++
 rtl/cpu_out_display.sv | 133 +++++++++++++
 tb/tb_cpu_out_display.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_out_display_if.sv
// Bus between the CPU output nibble and the seven-segment display block.
// The master side drives cpuOut; the slave (display) side drives the board-facing outputs.
interface cpu_out_display_if;
    logic [3:0]  cpuOut;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  anode;
    logic [15:0] history;
    logic [7:0]  changeCount;

    modport master (
        output cpuOut,
        input  seg, dp, anode, history, changeCount
    );

    modport slave (
        input  cpuOut,
        output seg, dp, anode, history, changeCount
    );
endinterface

// File: rtl/cpu_out_display.sv
// CPU output display: records a 4-deep history of distinct cpuOut values and
// scans them onto a multiplexed 4-digit seven-segment display.
module cpu_out_display #(
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic               boardCLK,
    input  logic               reset,
    cpu_out_display_if.slave   bus
);
    localparam int              PW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   TERM     = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic            DP_OFF   = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            4'hF:    s = 7'b1110001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic [3:0]    r_in;
    logic [3:0]    r_last;
    logic [15:0]   r_history;
    logic [7:0]    r_change_count;
    logic [PW-1:0] r_prescaler;
    logic [1:0]    r_digit_sel;
    logic [3:0]    r_anode;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_changed;
    logic [3:0]    w_nibble;
    logic [3:0]    w_anode_next;
    logic [6:0]    w_seg_next;
    logic          w_dp_on;
    logic          w_dp_next;

    assign w_changed = (r_in != r_last);

    // Select the nibble for the digit currently being scanned and form its drive levels.
    always_comb begin
        w_nibble = 4'h0;
        case (r_digit_sel)
            2'd0:    w_nibble = r_history[3:0];
            2'd1:    w_nibble = r_history[7:4];
            2'd2:    w_nibble = r_history[11:8];
            2'd3:    w_nibble = r_history[15:12];
            default: w_nibble = 4'h0;
        endcase
        w_anode_next = ~(4'b0001 << r_digit_sel);
        w_dp_on      = (r_digit_sel == 2'd0) && (r_change_count == 8'hFF);
        w_seg_next   = SEG_ACTIVE_LOW ? ~hex_to_seg(w_nibble) : hex_to_seg(w_nibble);
        w_dp_next    = SEG_ACTIVE_LOW ? ~w_dp_on : w_dp_on;
    end

    // Input synchronisation stage and change-detect history shift.
    always_ff @(posedge boardCLK) begin
        if (reset) begin
            r_in           <= 4'h0;
            r_last         <= 4'h0;
            r_history      <= 16'h0000;
            r_change_count <= 8'h00;
        end else begin
            r_in <= bus.cpuOut;
            if (w_changed) begin
                r_history <= {r_history[11:0], r_in};
                r_last    <= r_in;
                if (r_change_count != 8'hFF) begin
                    r_change_count <= r_change_count + 8'd1;
                end else begin
                    r_change_count <= r_change_count;
                end
            end else begin
                r_history      <= r_history;
                r_last         <= r_last;
                r_change_count <= r_change_count;
            end
        end
    end

    // Refresh prescaler; each terminal count advances the scanned digit (wrapping 3 -> 0).
    always_ff @(posedge boardCLK) begin
        if (reset) begin
            r_prescaler <= '0;
            r_digit_sel <= 2'd0;
        end else if (r_prescaler == TERM) begin
            r_prescaler <= '0;
            r_digit_sel <= r_digit_sel + 2'd1;
        end else begin
            r_prescaler <= r_prescaler + PW'(1);
            r_digit_sel <= r_digit_sel;
        end
    end

    // Registered display drive, so nothing on cpuOut reaches the pins combinationally.
    always_ff @(posedge boardCLK) begin
        if (reset) begin
            r_anode <= 4'b1111;
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
        end else begin
            r_anode <= w_anode_next;
            r_seg   <= w_seg_next;
            r_dp    <= w_dp_next;
        end
    end

    assign bus.seg         = r_seg;
    assign bus.dp          = r_dp;
    assign bus.anode       = r_anode;
    assign bus.history     = r_history;
    assign bus.changeCount = r_change_count;
endmodule

// File: tb/tb_cpu_out_display.sv
// Scoreboard bench for cpu_out_display: a high-level model pushes the expected
// outputs for every clock edge and a monitor process compares them after the edge.
module tb_cpu_out_display;
    localparam int DIV = 4;

    typedef struct {
        logic [3:0]  anode;
        logic [6:0]  seg;
        logic        dp;
        logic [15:0] hist;
        logic [7:0]  cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    cpu_out_display_if bus ();

    cpu_out_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .boardCLK (clk),
        .reset    (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tbl [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                                 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    // Reference model state: last sampled input, last recorded value,
    // newest-first list of recorded values, change count, cycles since reset.
    int m_in;
    int m_last;
    int m_hist[$];
    int m_cnt;
    int m_ticks;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic logic [15:0] model_hist_word();
        logic [15:0] w;
        w = 16'h0000;
        for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'(m_hist[i]);
        return w;
    endfunction

    // Drive inputs for the next edge, push the model's prediction, then take the edge.
    task automatic step(input logic [3:0] c, input logic r);
        exp_t e;
        int   digit;
        bus.cpuOut = c;
        rst        = r;
        if (r) begin
            m_in = 0; m_last = 0; m_cnt = 0; m_ticks = 0;
            m_hist = '{0, 0, 0, 0};
            e.anode = 4'b1111; e.seg = 7'h7F; e.dp = 1'b1;
        end else begin
            digit   = (m_ticks / DIV) % 4;
            e.anode = 4'b1111;
            e.anode[digit] = 1'b0;
            e.seg   = ~seg_tbl[m_hist[digit]];
            e.dp    = !((digit == 0) && (m_cnt == 255));
            if (m_in != m_last) begin
                m_hist.push_front(m_in);
                void'(m_hist.pop_back());
                m_last = m_in;
                if (m_cnt < 255) m_cnt++;
            end
            m_in = c;
            m_ticks++;
        end
        e.hist = model_hist_word();
        e.cnt  = 8'(m_cnt);
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one prediction per edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("anode",       {12'h000, bus.anode},       {12'h000, e.anode});
                check("seg",         {9'h000, bus.seg},          {9'h000, e.seg});
                check("dp",          {15'h0000, bus.dp},         {15'h0000, e.dp});
                check("history",     bus.history,                e.hist);
                check("changeCount", {8'h00, bus.changeCount},   {8'h00, e.cnt});
            end
        end
    end

    initial begin
        logic [3:0] v;
        logic [3:0] seq5 [5];
        logic [3:0] seq4 [4];
        bit         found;
        checks   = 0;
        failures = 0;
        seq5 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        seq4 = '{4'h1, 4'hE, 4'h8, 4'h0};

        // Reset with a nonzero input, then release.
        step(4'h5, 1'b1);
        step(4'h5, 1'b1);
        check("rst_anode",   {12'h000, bus.anode},     16'h000F);
        check("rst_seg",     {9'h000, bus.seg},        16'h007F);
        check("rst_history", bus.history,              16'h0000);
        check("rst_count",   {8'h00, bus.changeCount}, 16'h0000);
        step(4'h5, 1'b0);
        check("first_anode", {12'h000, bus.anode},     16'h000E);
        step(4'h5, 1'b0);
        check("rel_history", bus.history,              16'h0005);
        check("rel_count",   {8'h00, bus.changeCount}, 16'h0001);

        // Held value records once.
        step(4'h0, 1'b1);
        repeat (10) step(4'h3, 1'b0);
        step(4'h9, 1'b0);
        step(4'h9, 1'b0);
        check("hold_history", bus.history,              16'h0039);
        check("hold_count",   {8'h00, bus.changeCount}, 16'h0002);

        // Fifth distinct value drops the oldest.
        step(4'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(seq5[i], 1'b0);
        step(4'h5, 1'b0);
        check("drop_history", bus.history,              16'h2345);
        check("drop_count",   {8'h00, bus.changeCount}, 16'h0005);

        // Saturation and dp indicator.
        step(4'h0, 1'b1);
        for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 4'hA : 4'hB, 1'b0);
        step(4'hB, 1'b0);
        check("sat_count", {8'h00, bus.changeCount}, 16'h00FF);
        found = 1'b0;
        for (int i = 0; i < 4 * DIV + 2 && !found; i++) begin
            if (bus.anode == 4'b1110) begin
                found = 1'b1;
                check("sat_dp", {15'h0000, bus.dp}, 16'h0000);
            end else begin
                step(4'hB, 1'b0);
            end
        end
        if (!found) check("sat_dp_timeout", 16'h0000, 16'h0001);

        // Scan of 0x1E80 across two full rotations, then reset mid-scan at digit 2.
        step(4'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(seq4[i], 1'b0);
        step(4'h0, 1'b0);
        check("scan_history", bus.history, 16'h1E80);
        repeat (8 * DIV) step(4'h0, 1'b0);
        step(4'h0, 1'b1);
        repeat (2 * DIV + 2) step(4'h0, 1'b0);
        step(4'h7, 1'b1);
        check("midscan_anode",   {12'h000, bus.anode}, 16'h000F);
        check("midscan_history", bus.history,          16'h0000);
        repeat (2 * DIV) step(4'h7, 1'b0);

        // Randomised traffic with occasional resets.
        v = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) != 0) v = 4'($urandom_range(0, 15));
            step(v, ($urandom_range(0, 199) == 0));
        end

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
        #3;
        if (sb_q.size() > 0) check("scoreboard_drain", 16'(sb_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
